pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/redirect_sel.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// forward-select widths and values.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLdstall = 2'd1;
  localparam logic [1:0] StFlush   = 2'd2;
  localparam logic [1:0] StHalted  = 2'd3;

  localparam int unsigned MUX_EX_REDIR_DATAA_BIT = 2;
  localparam int unsigned MUX_EX_REDIR_DATAB_BIT = 2;

  localparam logic [1:0] MUX_EX_REDIR_NONE = 2'd0;
  localparam logic [1:0] MUX_EX_REDIR_ALU  = 2'd1;
  localparam logic [1:0] MUX_EX_REDIR_WB   = 2'd2;

  // Register 0 is hardwired, so it never counts as a producer.
  function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst,
                                   input logic w_en);
    return w_en && (dst != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/redirect_sel.sv
// Operand forward-select for one ID source register; EX producers win over DM,
// and loads in EX cannot forward yet.
module redirect_sel
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned SelW = MUX_EX_REDIR_DATAA_BIT
) (
  input  logic [4:0]      src,
  input  logic [4:0]      ex_req_w,
  input  logic            ex_w_en,
  input  logic            ex_is_load,
  input  logic [4:0]      dm_req_w,
  input  logic            dm_w_en,
  output logic [SelW-1:0] sel
);

  always_comb begin
    sel = SelW'(MUX_EX_REDIR_NONE);
    if (src_hit(src, ex_req_w, ex_w_en) && !ex_is_load) begin
      sel = SelW'(MUX_EX_REDIR_ALU);
    end else if (src_hit(src, dm_req_w, dm_w_en)) begin
      sel = SelW'(MUX_EX_REDIR_WB);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubbles, forwarding and halt.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [4:0]                        id_rs,
  input  logic [4:0]                        id_rt,
  input  logic                              id_use_rs,
  input  logic                              id_use_rt,
  input  logic [4:0]                        ex_req_w,
  input  logic                              ex_w_en,
  input  logic                              ex_is_load,
  input  logic [4:0]                        dm_req_w,
  input  logic                              dm_w_en,
  input  logic                              ex_branch_taken,
  input  logic                              wb_halt,
  input  logic                              mem_busy,
  output logic                              pc_en,
  output logic                              if_id_en,
  output logic                              id_ex_en,
  output logic                              ex_dm_en,
  output logic                              dm_wb_en,
  output logic                              if_id_clr,
  output logic                              id_ex_clr,
  output logic [MUX_EX_REDIR_DATAA_BIT-1:0] redir_a,
  output logic [MUX_EX_REDIR_DATAB_BIT-1:0] redir_b,
  output logic                              halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                       cnt_cycle,
  output logic [31:0]                       cnt_stall,
  output logic [31:0]                       cnt_flush
`endif
);

  logic [1:0] state_q, state_d;
  logic [4:0] stage_en;
  logic       load_use;

  assign load_use = ex_is_load && ex_w_en && (ex_req_w != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_req_w)) ||
                     (id_use_rt && (id_rt == ex_req_w)));

  assign {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = stage_en;

  always_comb begin
    state_d   = state_q;
    stage_en  = 5'b11111;
    if_id_clr = 1'b0;
    id_ex_clr = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      state_d = StRun;
    end else if (state_q == StHalted) begin
      stage_en = 5'b00000;
      halted   = 1'b1;
    end else if (wb_halt) begin
      stage_en = 5'b00000;
      state_d  = StHalted;
    end else if (mem_busy) begin
      stage_en = 5'b00000;
    end else if (ex_branch_taken) begin
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
      state_d   = StFlush;
    end else if (load_use && (state_q != StLdstall)) begin
      // Hold PC and IF/ID, push a bubble into EX while the load reaches DM.
      stage_en  = 5'b00111;
      id_ex_clr = 1'b1;
      state_d   = StLdstall;
    end else begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  redirect_sel #(
    .SelW(MUX_EX_REDIR_DATAA_BIT)
  ) u_redir_a (
    .src       (id_rs),
    .ex_req_w  (ex_req_w),
    .ex_w_en   (ex_w_en),
    .ex_is_load(ex_is_load),
    .dm_req_w  (dm_req_w),
    .dm_w_en   (dm_w_en),
    .sel       (redir_a)
  );

  redirect_sel #(
    .SelW(MUX_EX_REDIR_DATAB_BIT)
  ) u_redir_b (
    .src       (id_rt),
    .ex_req_w  (ex_req_w),
    .ex_w_en   (ex_w_en),
    .ex_is_load(ex_is_load),
    .dm_req_w  (dm_req_w),
    .dm_w_en   (dm_w_en),
    .sel       (redir_b)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic active, stall_evt, flush_evt;

  assign active    = (state_q != StHalted) && !wb_halt;
  assign stall_evt = active && (mem_busy ||
                     (!ex_branch_taken && load_use && (state_q != StLdstall)));
  assign flush_evt = active && !mem_busy && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_cycle <= 32'd0;
      cnt_stall <= 32'd0;
      cnt_flush <= 32'd0;
    end else if (state_q != StHalted) begin
      cnt_cycle <= cnt_cycle + 32'd1;
      if (stall_evt) cnt_stall <= cnt_stall + 32'd1;
      if (flush_evt) cnt_flush <= cnt_flush + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule
